// File: rtl/leds_seq_pkg.sv
// leds_seq_pkg: mode and direction encodings shared by the LED sequencer files.
package leds_seq_pkg;
    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
endpackage

// File: rtl/leds_seq_prescaler.sv
// leds_seq_prescaler: step tick generator, one tick every i_prescale+1 enabled cycles.
module leds_seq_prescaler
    import leds_seq_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [COUNTER_WIDTH-1:0] i_prescale,
    output logic                     o_tick
);
    logic [COUNTER_WIDTH-1:0] r_cnt;

    // >= rather than == so a lowered compare value ticks on the next cycle
    assign o_tick = i_enable && (r_cnt >= i_prescale);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/leds_sequencer.sv
// leds_sequencer: LED window sequencer (bounce/rotate/blink/hold) with registered outputs.
// Optional dimming of the DATA outputs is built when LEDS_SEQ_PWM_EN is defined.
module leds_sequencer
    import leds_seq_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int WIN_WIDTH     = 2,
`ifdef LEDS_SEQ_PWM_EN
    parameter int PWM_BITS      = 4,
`endif
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [1:0]               i_mode,
    input  logic [COUNTER_WIDTH-1:0] i_prescale,
`ifdef LEDS_SEQ_PWM_EN
    input  logic [PWM_BITS-1:0]      i_duty,
`endif
    output logic [NUM_LEDS-1:0]      o_data,
    output logic                     o_step,
    output logic                     o_wrap
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] PMAX = PW'(NUM_LEDS - WIN_WIDTH);
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [NUM_LEDS-1:0] RST_DATA = ~({NUM_LEDS{1'b1}} >> WIN_WIDTH);

    logic                w_tick;
    logic [PW-1:0]       r_pos, w_pos_nx;
    dir_t                r_dir, w_dir_nx;
    logic                r_phase, w_phase_nx, w_wrap_nx;
    logic [NUM_LEDS-1:0] r_data, w_win;

    leds_seq_prescaler #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_prescaler (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_prescale (i_prescale),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_pos_nx   = r_pos;
        w_dir_nx   = r_dir;
        w_phase_nx = r_phase;
        w_wrap_nx  = 1'b0;
        case (i_mode)
            MODE_BOUNCE: begin
                if (r_pos > PMAX) begin
                    w_pos_nx = PMAX;
                    w_dir_nx = DIR_DOWN;
                end else if (PMAX == '0) begin
                    w_wrap_nx = 1'b1;
                end else if (r_dir == DIR_DOWN) begin
                    w_pos_nx  = (r_pos == '0) ? ONE : r_pos - ONE;
                    w_dir_nx  = (r_pos == '0) ? DIR_UP : DIR_DOWN;
                    w_wrap_nx = (r_pos == '0);
                end else begin
                    w_pos_nx  = (r_pos == PMAX) ? PMAX - ONE : r_pos + ONE;
                    w_dir_nx  = (r_pos == PMAX) ? DIR_DOWN : DIR_UP;
                    w_wrap_nx = (r_pos == PMAX);
                end
            end
            MODE_ROTATE: begin
                w_pos_nx  = (r_pos == LAST) ? '0 : r_pos + ONE;
                w_wrap_nx = (r_pos == LAST);
            end
            MODE_BLINK: begin
                w_phase_nx = ~r_phase;
                w_wrap_nx  = r_phase;
            end
            default: ;
        endcase
    end

    // window indices taken mod NUM_LEDS; bounce keeps pos<=PMAX so it never wraps
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            w_win[i] = ((i + NUM_LEDS - int'(w_pos_nx)) % NUM_LEDS) < WIN_WIDTH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos   <= PMAX;
            r_dir   <= DIR_DOWN;
            r_phase <= 1'b1;
            r_data  <= RST_DATA;
            o_step  <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            o_step <= w_tick;
            o_wrap <= w_tick && w_wrap_nx;
            if (w_tick) begin
                r_pos   <= w_pos_nx;
                r_dir   <= w_dir_nx;
                r_phase <= w_phase_nx;
                r_data  <= (i_mode == MODE_BLINK) ? {NUM_LEDS{w_phase_nx}} : w_win;
            end
        end
    end

`ifdef LEDS_SEQ_PWM_EN
    logic [PWM_BITS-1:0] r_pcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + 1'b1;
    end

    assign o_data = r_data & {NUM_LEDS{r_pcnt < i_duty}};
`else
    assign o_data = r_data;
`endif
endmodule

// File: tb/tb_leds_sequencer.sv
// tb_leds_sequencer: directed checks of leds_sequencer (8/2 and 4/4 instances).
// Builds with or without LEDS_SEQ_PWM_EN; dimming checks are added when it is defined.
module tb_leds_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [23:0] prescale = '0;
    logic [7:0]  data;
    logic        step, wrap;
    logic [3:0]  data4;
    logic        step4, wrap4;
    int          n_pass = 0;
    int          n_total = 0;
`ifdef LEDS_SEQ_PWM_EN
    logic [3:0]  duty = 4'hF;
    logic [3:0]  m_pcnt;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_pcnt <= '0;
        else m_pcnt <= m_pcnt + 1'b1;
`endif

    always #5 clk = ~clk;

    leds_sequencer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_mode     (mode),
        .i_prescale (prescale),
`ifdef LEDS_SEQ_PWM_EN
        .i_duty     (duty),
`endif
        .o_data     (data),
        .o_step     (step),
        .o_wrap     (wrap)
    );

    leds_sequencer #(.NUM_LEDS(4), .WIN_WIDTH(4)) dut4 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_mode     (mode),
        .i_prescale (prescale),
`ifdef LEDS_SEQ_PWM_EN
        .i_duty     (duty),
`endif
        .o_data     (data4),
        .o_step     (step4),
        .o_wrap     (wrap4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // expected DATA after dimming; full brightness when dimming is not built
    function automatic logic [7:0] ed(input logic [7:0] x);
`ifdef LEDS_SEQ_PWM_EN
        return (m_pcnt < duty) ? x : 8'h00;
`else
        return x;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] bd [14] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06,
                            8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60, 8'h30};
    logic       bw [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int nsteps;
        int nlit;
        @(negedge clk);
        check("rst_data", data, ed(8'hC0));
        check("rst_step", step, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_data4", {4'h0, data4}, ed(8'h0F));
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("bounce_data", data, ed(bd[k]));
            check("bounce_wrap", wrap, bw[k]);
            check("bounce_step", step, 1'b1);
            check("full_data4", {4'h0, data4}, ed(8'h0F));
            check("full_wrap4", wrap4, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", data, ed(8'hC0));
        check("async_rst_step", step, 1'b0);
        check("async_rst_wrap", wrap, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("restart_data", data, ed(bd[k]));
            check("restart_wrap", wrap, bw[k]);
        end
        mode = 2'b01;
        do_reset();
        @(negedge clk);
        check("rot_to_pos7", data, ed(8'h81));
        mode = 2'b00;
        @(negedge clk);
        check("enter_bounce_data", data, ed(8'hC0));
        check("enter_bounce_wrap", wrap, 1'b0);
        @(negedge clk);
        check("enter_bounce_next", data, ed(8'h60));
        mode = 2'b01;
        prescale = 24'd3;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("rot_step", step, (c % 4) == 0);
            check("rot_wrap", wrap, c == 8);
            check("rot_data", data, ed(c < 4 ? 8'hC0 : c < 8 ? 8'h81 : c < 12 ? 8'h03 : 8'h06));
        end
        mode = 2'b10;
        prescale = '0;
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("blink_data", data, ed(c[0] ? 8'h00 : 8'hFF));
            check("blink_wrap", wrap, c[0]);
        end
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("frozen_data", data, 8'h00);
            check("frozen_step", step, 1'b0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_data", data, ed(8'hFF));
        check("resume_wrap", wrap, 1'b0);
        check("resume_step", step, 1'b1);
        mode = 2'b11;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("hold_data", data, ed(8'hC0));
            check("hold_step", step, 1'b1);
            check("hold_wrap", wrap, 1'b0);
        end
        prescale = 24'd10;
        do_reset();
        repeat (5) @(negedge clk);
        prescale = 24'd100;
        nsteps = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            nsteps += int'(step);
        end
        check("no_early_tick", nsteps, 0);
        prescale = 24'd2;
        @(negedge clk);
        check("lowered_tick", step, 1'b1);
`ifdef LEDS_SEQ_PWM_EN
        prescale = 24'd1000;
        duty = 4'd0;
        do_reset();
        nlit = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            nlit += int'(data != 8'h00);
        end
        check("duty0_lit", nlit, 0);
        duty = 4'd8;
        nlit = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            nlit += int'(data == 8'hC0);
        end
        check("duty8_lit", nlit, 8);
        duty = 4'hF;
`else
        nlit = 0;
        check("no_pwm_lit", nlit, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
